// File: rtl/axi_wr_addr_slave.sv
// AXI write-address channel slave: FWFT command queue with precomputed beat count and protocol checker.
// Latency: push at edge N presents the command after edge N; awready is registered (one bubble after a pop at full).
// Backpressure: awready deasserts when the queue will be full; cmd_* held stable while cmd_valid && !cmd_ready.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   awvalid/awready     - AW handshake; awid/awlen/awaddr are the request payload
//   cmd_valid/cmd_ready - head-of-queue command handshake; cmd_id/cmd_addr/cmd_beats = head entry
//   occupancy           - number of queued commands (0..DEPTH)
//   proto_err           - sticky flag: initiator changed or withdrew a request that was waiting for awready
// Optional build macro AXI_WR_ADDR_SLV_STATS_EN adds acc_count (wrapping handshake count) and
// full_cycles (saturating count of cycles spent full).

module axi_wr_addr_slave #(
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ID_W-1:0]          awid,
  input  logic [LEN_W-1:0]         awlen,
  input  logic [ADDR_W-1:0]        awaddr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ID_W-1:0]          cmd_id,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [LEN_W:0]           cmd_beats,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     proto_err
`ifdef AXI_WR_ADDR_SLV_STATS_EN
  ,
  output logic [15:0]              acc_count,
  output logic [15:0]              full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W:0]    beats;
  } cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } chk_state_e;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             awready_q, awready_d;
  logic             push, pop;
  cmd_t             wr_ent, head;

  chk_state_e        state_q;
  logic              proto_err_q;
  logic [ID_W-1:0]   lat_id_q;
  logic [LEN_W-1:0]  lat_len_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic              payload_diff;

  assign push = awvalid && awready_q;
  assign pop  = (occ_q != '0) && cmd_ready;

  // Beat count is formed on entry so the write engine never needs the +1 adder.
  assign wr_ent.id    = awid;
  assign wr_ent.addr  = awaddr;
  assign wr_ent.beats = {1'b0, awlen} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    // Looking at the next level (not the current one) keeps awready registered
    // without ever overfilling the queue.
    awready_d = (occ_d < FULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      awready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q     <= occ_d;
      awready_q <= awready_d;
    end
  end

  // Storage has no reset; contents are only observed while cmd_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_ent;
  end

  assign head      = mem_q[rd_ptr_q];
  assign cmd_valid = (occ_q != '0);
  assign cmd_id    = head.id;
  assign cmd_addr  = head.addr;
  assign cmd_beats = head.beats;
  assign occupancy = occ_q;
  assign awready   = awready_q;

  // Protocol checker: once a request is stalled it must stay valid with an
  // unchanged payload until it is accepted.
  assign payload_diff = (awid != lat_id_q) || (awaddr != lat_addr_q) || (awlen != lat_len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
      lat_id_q    <= '0;
      lat_len_q   <= '0;
      lat_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (awvalid && !awready_q) begin
            state_q    <= ST_PEND;
            lat_id_q   <= awid;
            lat_len_q  <= awlen;
            lat_addr_q <= awaddr;
          end
        end
        ST_PEND: begin
          if (!awvalid || payload_diff) begin
            proto_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (awready_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign proto_err = proto_err_q;

`ifdef AXI_WR_ADDR_SLV_STATS_EN
  logic [15:0] acc_count_q, full_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count_q   <= '0;
      full_cycles_q <= '0;
    end else begin
      if (push) acc_count_q <= acc_count_q + 16'd1;
      if ((occ_q == FULL_LVL) && (full_cycles_q != 16'hFFFF)) begin
        full_cycles_q <= full_cycles_q + 16'd1;
      end
    end
  end

  assign acc_count   = acc_count_q;
  assign full_cycles = full_cycles_q;
`endif

endmodule
